// File: rtl/lsq_controller.sv
// Load/store queue controller: in-order FIFO of committed loads/stores issued one at a time over a req/ack port.
// Define LSQ_REG_LOAD_DATA_EN to register load writeback in a dedicated WB state.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module lsq_controller #(
    parameter int DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                resetb_i,
    input  logic                clk_en_i,
    input  logic                lq_wr_i,
    input  logic                sq_wr_i,
    input  logic [2:0]          funct3_i,
    input  logic [4:0]          regd_addr_i,
    input  logic [`RV_XLEN-1:0] regs2_data_i,
    input  logic [`RV_XLEN-1:0] addr_i,
    output logic                full_o,
    output logic                empty_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [`RV_XLEN-1:0] dmem_addr_o,
    output logic [3:0]          dmem_be_o,
    output logic [`RV_XLEN-1:0] dmem_wdata_o,
    input  logic                dmem_ack_i,
    input  logic [`RV_XLEN-1:0] dmem_rdata_i,
    output logic                regd_wr_o,
    output logic [4:0]          regd_addr_o,
    output logic [`RV_XLEN-1:0] regd_data_o
);
    localparam int XLEN = `RV_XLEN;
    localparam int PW   = $clog2(DEPTH);

    typedef struct packed {
        logic            is_store;
        logic [2:0]      funct3;
        logic [4:0]      regd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] addr;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
`ifdef LSQ_REG_LOAD_DATA_EN
        ST_WB,
`endif
        ST_REQ
    } state_t;

    entry_t        slot_q [DEPTH];
    entry_t        slot_d;
    entry_t        head;
    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push, pop;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] data);
        case (size)
            2'b00:   store_data = {(XLEN/8){data[7:0]}};
            2'b01:   store_data = {(XLEN/16){data[15:0]}};
            default: store_data = data;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] lane;
        lane = rdata >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   load_ext = {{(XLEN-8){~f3[2] & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{(XLEN-16){~f3[2] & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    endfunction

    assign head   = slot_q[rd_ptr_q];
    assign push   = (lq_wr_i | sq_wr_i) & ~full_o;
    assign pop    = (state_q == ST_REQ) & dmem_ack_i;
    assign slot_d = '{is_store: sq_wr_i, funct3: funct3_i, regd: regd_addr_i,
                      data: regs2_data_i, addr: addr_i};

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0) && (state_q == ST_IDLE);

    // Memory-side outputs are gated by req so nothing leaks from stale slots.
    assign dmem_req_o   = (state_q == ST_REQ);
    assign dmem_we_o    = dmem_req_o & head.is_store;
    assign dmem_addr_o  = dmem_req_o ? {head.addr[XLEN-1:2], 2'b00} : '0;
    assign dmem_be_o    = dmem_req_o ? byte_en(head.funct3[1:0], head.addr[1:0]) : '0;
    assign dmem_wdata_o = dmem_we_o ? store_data(head.funct3[1:0], head.data) : '0;

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clk_en_i) begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            case (state_q)
                ST_IDLE: if (count_q != '0) state_d = ST_REQ;
                ST_REQ: begin
                    if (pop) begin
                        state_d = (count_d != '0) ? ST_REQ : ST_IDLE;
`ifdef LSQ_REG_LOAD_DATA_EN
                        if (!head.is_store) state_d = ST_WB;
`endif
                    end
                end
`ifdef LSQ_REG_LOAD_DATA_EN
                ST_WB:   state_d = (count_d != '0) ? ST_REQ : ST_IDLE;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: slot storage is not reset; validity comes only from the pointers and count.
    always_ff @(posedge clk_i) begin
        if (clk_en_i && push) slot_q[wr_ptr_q] <= slot_d;
    end

`ifdef LSQ_REG_LOAD_DATA_EN
    logic [4:0]      regd_addr_q, regd_addr_d;
    logic [XLEN-1:0] regd_data_q, regd_data_d;

    always_comb begin
        regd_addr_d = regd_addr_q;
        regd_data_d = regd_data_q;
        if (clk_en_i && pop && !head.is_store) begin
            regd_addr_d = head.regd;
            regd_data_d = load_ext(head.funct3, head.addr[1:0], dmem_rdata_i);
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            regd_addr_q <= '0;
            regd_data_q <= '0;
        end else begin
            regd_addr_q <= regd_addr_d;
            regd_data_q <= regd_data_d;
        end
    end

    assign regd_wr_o   = (state_q == ST_WB);
    assign regd_addr_o = regd_addr_q;
    assign regd_data_o = regd_data_q;
`else
    assign regd_wr_o   = dmem_req_o & dmem_ack_i & ~dmem_we_o;
    assign regd_addr_o = regd_wr_o ? head.regd : '0;
    assign regd_data_o = regd_wr_o ? load_ext(head.funct3, head.addr[1:0], dmem_rdata_i) : '0;
`endif

endmodule

// File: tb/tb_lsq_controller.sv
// Self-checking bench for lsq_controller: directed test-plan steps plus randomized traffic
// scored against a queue-based reference model.
module tb_lsq_controller;
    localparam int DEPTH = 4;

    typedef struct {
        bit          st;
        bit [2:0]    f3;
        bit [4:0]    rd;
        logic [31:0] data;
        logic [31:0] addr;
    } tb_ent_t;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        clk_en = 1'b1;
    logic        lq_wr = 1'b0;
    logic        sq_wr = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  regd_in = '0;
    logic [31:0] regs2 = '0;
    logic [31:0] addr_in = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        full_o, empty_o, dmem_req_o, dmem_we_o, regd_wr_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, regd_data_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  regd_addr_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    int          base, guard;
    tb_ent_t     mq[$];
    bit          wb_pend = 0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    bit          prev_req = 0;
    bit          prev_pop = 0;
    bit          r_st;
    int          r_sz;
    logic [2:0]  r_f3;
    logic [31:0] r_a;

    lsq_controller #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
        .lq_wr_i(lq_wr), .sq_wr_i(sq_wr), .funct3_i(funct3),
        .regd_addr_i(regd_in), .regs2_data_i(regs2), .addr_i(addr_in),
        .full_o(full_o), .empty_o(empty_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata),
        .regd_wr_o(regd_wr_o), .regd_addr_o(regd_addr_o), .regd_data_o(regd_data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_be(input tb_ent_t e);
        int unsigned off = int'(e.addr % 4);
        case (e.f3[1:0])
            2'b00:   return 4'(1 << off);
            2'b01:   return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input tb_ent_t e);
        case (e.f3[1:0])
            2'b00:   return (e.data & 32'hFF) * 32'h01010101;
            2'b01:   return (e.data & 32'hFFFF) * 32'h00010001;
            default: return e.data;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input tb_ent_t e, input logic [31:0] rdata);
        int unsigned v = rdata >> (8 * int'(e.addr % 4));
        case (e.f3[1:0])
            2'b00: begin
                v = v % 256;
                if (!e.f3[2] && v >= 128) v = v - 256;
            end
            2'b01: begin
                v = v % 65536;
                if (!e.f3[2] && v >= 32768) v = v - 65536;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    task automatic drive_push(input bit st, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] d, input logic [31:0] a);
        sq_wr = st; lq_wr = !st; funct3 = f3; regd_in = rd; regs2 = d; addr_in = a;
    endtask

    task automatic drive_idle();
        lq_wr = 1'b0; sq_wr = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete(); wb_pend = 0; prev_req = 0; prev_pop = 0;
    endtask

    // One clock: score outputs against the model, take the edge, then advance the model.
    task automatic tick();
        bit          s_req, s_ack, s_en, s_push, accept, exp_wr;
        logic [31:0] s_rdata;
        tb_ent_t     cur, h;
        #1;
        check("full", full_o, mq.size() == DEPTH);
        check("empty", empty_o, mq.size() == 0 && !wb_pend);
        if (prev_req && !prev_pop) check("req_held_until_ack", dmem_req_o, 1);
        if (dmem_req_o === 1'b1) begin
            if (mq.size() == 0) check("req_with_empty_model", dmem_req_o, 0);
            else begin
                h = mq[0];
                check("we", dmem_we_o, h.st);
                check("addr", dmem_addr_o, h.addr & ~32'h3);
                check("be", dmem_be_o, exp_be(h));
                if (h.st) check("wdata", dmem_wdata_o, exp_wdata(h));
            end
        end
`ifdef LSQ_REG_LOAD_DATA_EN
        check("regd_wr", regd_wr_o, wb_pend);
        if (wb_pend) begin
            check("regd_addr", regd_addr_o, wb_rd);
            check("regd_data", regd_data_o, wb_data);
        end
`else
        exp_wr = (dmem_req_o === 1'b1) && dmem_ack && mq.size() > 0 && !mq[0].st;
        check("regd_wr", regd_wr_o, exp_wr);
        if (exp_wr) begin
            check("regd_addr", regd_addr_o, mq[0].rd);
            check("regd_data", regd_data_o, exp_load(mq[0], dmem_rdata));
        end
`endif
        s_req   = (dmem_req_o === 1'b1);
        s_ack   = dmem_ack;
        s_en    = clk_en;
        s_push  = lq_wr | sq_wr;
        s_rdata = dmem_rdata;
        cur     = '{st: sq_wr, f3: funct3, rd: regd_in, data: regs2, addr: addr_in};
        @(posedge clk);
        prev_pop = 0;
        if (s_en) begin
            wb_pend = 0;
            accept  = s_push && mq.size() < DEPTH;
            if (s_req && s_ack && mq.size() > 0) begin
                h = mq.pop_front();
                n_pops++;
                prev_pop = 1;
`ifdef LSQ_REG_LOAD_DATA_EN
                if (!h.st) begin
                    wb_pend = 1; wb_rd = h.rd; wb_data = exp_load(h, s_rdata);
                end
`endif
            end
            if (accept) mq.push_back(cur);
        end
        prev_req = s_req;
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_req", dmem_req_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_regd_wr", regd_wr_o, 0);
        check("rst_dmem_addr", dmem_addr_o, 0);
        check("rst_be", dmem_be_o, 0);
        check("rst_wdata", dmem_wdata_o, 0);
        check("rst_regd_data", regd_data_o, 0);
        @(posedge clk); #1;
        resetb = 1'b1;
        model_reset();
        tick();

        // SW 0x100 <- 0xDEADBEEF with immediate ack
        drive_push(1, 3'b010, 5'd0, 32'hDEADBEEF, 32'h100);
        tick();
        drive_idle();
        check("sw_no_req_yet", dmem_req_o, 0);
        check("sw_busy", empty_o, 0);
        tick();
        check("sw_req", dmem_req_o, 1);
        check("sw_addr", dmem_addr_o, 32'h100);
        check("sw_be", dmem_be_o, 4'b1111);
        check("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("sw_req_drop", dmem_req_o, 0);
        check("sw_empty_again", empty_o, 1);

        // SB 0x103 <- 0xA5
        drive_push(1, 3'b000, 5'd0, 32'h000000A5, 32'h103);
        tick();
        drive_idle();
        tick();
        check("sb_addr", dmem_addr_o, 32'h100);
        check("sb_be", dmem_be_o, 4'b1000);
        check("sb_wdata", dmem_wdata_o, 32'hA5A5A5A5);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;

        // LB x5 and LHU x6 from 0x102 with rdata 0x0080FF00
        drive_push(0, 3'b000, 5'd5, 32'h0, 32'h102);
        tick();
        drive_push(0, 3'b101, 5'd6, 32'h0, 32'h102);
        tick();
        drive_idle();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0080FF00;
        #1;
`ifdef LSQ_REG_LOAD_DATA_EN
        check("lb_no_wb_in_ack", regd_wr_o, 0);
        tick();
        check("lb_wb", regd_wr_o, 1);
        check("lb_rd", regd_addr_o, 5);
        check("lb_data", regd_data_o, 32'hFFFFFF80);
        check("lb_wb_no_req", dmem_req_o, 0);
        tick();
        check("lhu_req", dmem_req_o, 1);
        tick();
        dmem_ack = 1'b0;
        check("lhu_wb", regd_wr_o, 1);
        check("lhu_rd", regd_addr_o, 6);
        check("lhu_data", regd_data_o, 32'h00000080);
        tick();
`else
        check("lb_wb", regd_wr_o, 1);
        check("lb_rd", regd_addr_o, 5);
        check("lb_data", regd_data_o, 32'hFFFFFF80);
        tick();
        check("lhu_wb", regd_wr_o, 1);
        check("lhu_rd", regd_addr_o, 6);
        check("lhu_data", regd_data_o, 32'h00000080);
        tick();
        dmem_ack = 1'b0;
        #1;
`endif
        check("ld_done_no_wr", regd_wr_o, 0);
        check("ld_done_empty", empty_o, 1);

        // Fill to DEPTH with ack held low, drop a fifth push, then drain
        for (int i = 0; i < DEPTH; i++) begin
            drive_push(1, 3'b010, 5'd0, 32'h1000 + i, 32'h200 + 4 * i);
            tick();
        end
        drive_idle();
        check("full_after_4", full_o, 1);
        drive_push(1, 3'b010, 5'd0, 32'h55, 32'h2F0);
        tick();
        drive_idle();
        check("full_after_drop", full_o, 1);
        base = n_pops;
        dmem_ack = 1'b1;
        tick();
        check("full_falls_after_pop", full_o, 0);
        guard = 0;
        while (mq.size() != 0 && guard < 20) begin tick(); guard++; end
        check("full_drain_timeout", guard < 20, 1);
        dmem_ack = 1'b0;
        tick();
        check("full_pop_count", n_pops - base, DEPTH);

        // Simultaneous push/pop holding two entries, 8 pushes total across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive_push(1, 3'b010, 5'd0, 32'h3000 + i, 32'h400 + 4 * i);
            tick();
        end
        dmem_ack = 1'b1;
        for (int i = 2; i < 8; i++) begin
            drive_push(1, 3'b010, 5'd0, 32'h3000 + i, 32'h400 + 4 * i);
            tick();
        end
        drive_idle();
        check("pp_not_full", full_o, 0);
        check("pp_not_empty", empty_o, 0);
        base = n_pops;
        guard = 0;
        while (mq.size() != 0 && guard < 20) begin tick(); guard++; end
        check("pp_drain_timeout", guard < 20, 1);
        check("pp_count_stayed_2", n_pops - base, 2);
        dmem_ack = 1'b0;
        tick();

        // Randomized traffic with random ack and clock enable
        for (int c = 0; c < 600; c++) begin
            clk_en     = ($urandom_range(0, 9) != 0);
            dmem_ack   = $urandom_range(0, 1);
            dmem_rdata = $urandom;
            drive_idle();
            if ($urandom_range(0, 1) == 1 && mq.size() < DEPTH) begin
                r_st = $urandom_range(0, 1);
                r_sz = $urandom_range(0, 2);
                r_f3 = 3'(r_sz);
                if (!r_st && r_sz != 2 && $urandom_range(0, 1) == 1) r_f3[2] = 1'b1;
                r_a = $urandom & ~32'h3;
                if (r_sz == 0) r_a[1:0] = 2'($urandom_range(0, 3));
                else if (r_sz == 1) r_a[1] = 1'($urandom_range(0, 1));
                drive_push(r_st, r_f3, 5'($urandom), $urandom, r_a);
            end
            tick();
        end
        drive_idle();
        clk_en = 1'b1;
        dmem_ack = 1'b1;
        guard = 0;
        while ((mq.size() != 0 || wb_pend) && guard < 40) begin tick(); guard++; end
        check("rand_drain_timeout", guard < 40, 1);
        dmem_ack = 1'b0;
        tick();
        check("rand_final_empty", empty_o, 1);

        // Reset while a load request waits for ack
        drive_push(0, 3'b010, 5'd7, 32'h0, 32'h300);
        tick();
        drive_idle();
        tick();
        check("rst_mid_req_up", dmem_req_o, 1);
        #2;
        resetb = 1'b0;
        #1;
        check("rst_mid_req_drop", dmem_req_o, 0);
        check("rst_mid_empty", empty_o, 1);
        check("rst_mid_regd_wr", regd_wr_o, 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        resetb = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rst_after_empty", empty_o, 1);
        check("rst_after_no_wb", regd_wr_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
